// File: rtl/ex_mdu.sv
// ex_mdu: EX-stage multi-cycle multiply/divide unit holding HI/LO; MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU
module ex_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic        start,
  input  logic        cancel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        rd_hi,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  logic [31:0] a_q, b_q, ma, mb, q, r, quo, rem;
  logic [3:0] op_q;
  logic [CW-1:0] cnt;
  logic [63:0] sa, sb, prod, hilo, res;
  logic is_mul, is_div, is_mac, multi, sgn;
  assign is_mul = op == 4'd1 || op == 4'd2;
  assign is_div = op == 4'd3 || op == 4'd4;
`ifdef MDU_MADD_EN
  assign is_mac = op >= 4'd7 && op <= 4'd10;
`else
  assign is_mac = 1'b0;
`endif
  assign multi = is_mul | is_div | is_mac;
  assign stall_req = busy | (start & ~cancel & multi);
  assign rdata = rd_hi ? HI : LO;
  assign hilo = {HI, LO};
  assign sgn = op_q == 4'd1 || op_q == 4'd3 || op_q == 4'd7 || op_q == 4'd9;
  assign sa = sgn ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
  assign sb = sgn ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
  assign prod = sa * sb;
  // Signed divide works on magnitudes so 0x80000000 / -1 needs no special case
  assign ma = (sgn & a_q[31]) ? -a_q : a_q;
  assign mb = (sgn & b_q[31]) ? -b_q : b_q;
  assign q = mb == 32'd0 ? 32'd0 : ma / mb;
  assign r = mb == 32'd0 ? 32'd0 : ma % mb;
  assign quo = (sgn & (a_q[31] ^ b_q[31])) ? -q : q;
  assign rem = (sgn & a_q[31]) ? -r : r;
  always_comb begin
    res = hilo;
    res = (op_q == 4'd1 || op_q == 4'd2) ? prod :
          (op_q == 4'd3 || op_q == 4'd4) ? (b_q == 32'd0 ? hilo : {rem, quo}) :
          (op_q == 4'd7 || op_q == 4'd8) ? hilo + prod :
          (op_q == 4'd9 || op_q == 4'd10) ? hilo - prod : hilo;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
      busy <= 1'b0;
      cnt <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        {HI, LO} <= res;
        busy <= 1'b0;
      end
    end else if (start && !cancel) begin
      if (multi) begin
        a_q <= A;
        b_q <= B;
        op_q <= op;
        cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        busy <= 1'b1;
      end else if (op == 4'd5) begin
        HI <= A;
      end else if (op == 4'd6) begin
        LO <= A;
      end
    end
  end
endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: table-driven directed checks of ex_mdu plus multi-cycle corner sequences
module tb_ex_mdu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] op = '0;
  logic start = 1'b0;
  logic cancel = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic rd_hi = 1'b0;
  logic [31:0] rdata, HI, LO;
  logic busy, stall_req;
  int errors = 0;
  int checks = 0;

  ex_mdu dut (
    .clk(clk), .reset(reset), .op(op), .start(start), .cancel(cancel),
    .A(A), .B(B), .rd_hi(rd_hi), .rdata(rdata), .busy(busy),
    .stall_req(stall_req), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic [3:0] op;
    logic [31:0] a, b, hi, lo;
    int cyc;
  } vec_t;

  vec_t v[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op for one cycle, then count busy cycles (bounded)
  task automatic go(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                    input logic multi, output int n);
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1;
    #1 check("stall_req_on_issue", {31'b0, stall_req}, {31'b0, multi});
    @(negedge clk);
    start = 1'b0; op = '0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    v[0] = '{"mult_neg", 4'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    v[1] = '{"multu", 4'd2, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5};
    v[2] = '{"div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    v[3] = '{"div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10};
    v[4] = '{"divu", 4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10};
    v[5] = '{"mult_min", 4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 5};
    v[6] = '{"div_negdiv", 4'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10};
    v[7] = '{"divu_big", 4'd4, 32'hFFFFFFFF, 32'd10, 32'd5, 32'h19999999, 10};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rd_hi = 1'b0;
    #1 check("reset_rdata_lo", rdata, 32'h0);
    rd_hi = 1'b1;
    #1 check("reset_rdata_hi", rdata, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_stall", {31'b0, stall_req}, 32'h0);

    foreach (v[i]) begin
      go(v[i].op, v[i].a, v[i].b, 1'b1, n);
      check({v[i].name, "_cycles"}, n, v[i].cyc);
      check({v[i].name, "_hi"}, HI, v[i].hi);
      check({v[i].name, "_lo"}, LO, v[i].lo);
    end

    go(4'd6, 32'hABCD, 32'h0, 1'b0, n);
    check("mtlo_nobusy", n, 0);
    go(4'd5, 32'h1234, 32'h0, 1'b0, n);
    check("mthi", HI, 32'h1234);
    rd_hi = 1'b1;
    #1 check("rdata_hi", rdata, 32'h1234);
    rd_hi = 1'b0;
    #1 check("rdata_lo", rdata, 32'hABCD);
    go(4'd4, 32'd55, 32'd0, 1'b1, n);
    check("divz_cycles", n, 10);
    check("divz_hi", HI, 32'h1234);
    check("divz_lo", LO, 32'hABCD);

    // MTHI and a second MULT while busy are ignored; old values visible meanwhile
    @(negedge clk);
    op = 4'd1; A = 32'd2; B = 32'd3; start = 1'b1;
    @(negedge clk);
    op = 4'd5; A = 32'hDEAD;
    #1 check("busy_stall", {31'b0, stall_req}, 32'h1);
    check("busy_old_lo", rdata, 32'hABCD);
    @(negedge clk);
    op = 4'd1; A = 32'd9; B = 32'd9;
    @(negedge clk);
    start = 1'b0; op = '0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("ign_hi", HI, 32'h0);
    check("ign_lo", LO, 32'd6);

    // cancel suppresses start
    @(negedge clk);
    op = 4'd3; A = 32'd20; B = 32'd3; start = 1'b1; cancel = 1'b1;
    #1 check("cancel_stall", {31'b0, stall_req}, 32'h0);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; op = '0;
    check("cancel_busy", {31'b0, busy}, 32'h0);
    repeat (12) @(negedge clk);
    check("cancel_lo", LO, 32'd6);

    // reset in the third busy cycle discards the multiply
    @(negedge clk);
    op = 4'd2; A = 32'd7; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = '0;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_hi", HI, 32'h0);
    check("midrst_lo", LO, 32'h0);
    repeat (8) @(negedge clk);
    check("midrst_late_lo", LO, 32'h0);

`ifdef MDU_MADD_EN
    go(4'd6, 32'd5, 32'd0, 1'b0, n);
    go(4'd7, 32'd2, 32'd3, 1'b1, n);
    check("madd_cycles", n, 5);
    check("madd_hi", HI, 32'h0);
    check("madd_lo", LO, 32'd11);
    go(4'd10, 32'd1, 32'd12, 1'b1, n);
    check("msubu_hi", HI, 32'hFFFFFFFF);
    check("msubu_lo", LO, 32'hFFFFFFFF);
`else
    go(4'd6, 32'd5, 32'd0, 1'b0, n);
    go(4'd7, 32'd2, 32'd3, 1'b0, n);
    check("op7_busy", n, 0);
    check("op7_hi", HI, 32'h0);
    check("op7_lo", LO, 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Multiply/divide unit of the EX stage, directly upstream of the MEM stage.
- Executes MULT/MULTU/DIV/DIVU over a fixed number of cycles and holds the HI/LO architectural registers.
- Services MTHI/MTLO writes and MFHI/MFLO reads.
- Drives a busy/stall request to the pipeline hazard controller so that dependent HI/LO instructions wait in EX.

Parameters:
- MULT_CYCLES, 5, cycles busy is high after a multiply is accepted (must be >= 1).
- DIV_CYCLES, 10, cycles busy is high after a divide is accepted (must be >= 1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; other codes are NONE.
- start  input  1  op valid this cycle (EX instruction not stalled).
- cancel  input  1  EX instruction is being flushed (kernel entry); suppresses start this cycle.
- A  input  32  rs operand, already forwarded.
- B  input  32  rt operand, already forwarded.
- rd_hi  input  1  1 selects HI on rdata, 0 selects LO.
- rdata  output  32  HI or LO, combinational from the registers.
- busy  output  1  operation in flight.
- stall_req  output  1  busy OR (start & !cancel & op is a multi-cycle op).
- HI  output  32  current HI register.
- LO  output  32  current LO register.

Behaviour:
- Reset (synchronous): HI=0, LO=0, busy=0, counter=0, latched operands/op cleared. Any in-flight result is discarded. Outputs are 0 in the cycle after reset is sampled.
- Accept: a multi-cycle op is accepted at posedge T when start=1, cancel=0, busy=0. At T it latches A, B and op, loads counter=N (MULT_CYCLES or DIV_CYCLES), and sets busy=1.
- Completion: counter decrements each cycle while busy. At the edge where counter==1, HI/LO are written and busy clears. busy is therefore high for exactly N cycles, and the new HI/LO are visible the cycle busy falls.
- Start while busy: ignored, no state change. The hazard unit must hold the instruction via stall_req.
- MTHI/MTLO: take effect at the accepting edge (start=1, cancel=0, busy=0), writing A into HI or LO. If busy=1 they are ignored; stall_req does not assert for them, and the hazard unit stalls using busy.
- cancel=1: no state change from op at that edge. An operation already in flight continues to completion; the hazard unit must not issue a cancel against an in-flight op.
- MULT: {HI,LO} = signed A*B, full 64 bits. MULTU: unsigned 64-bit product.
- DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (B=0, DIV or DIVU): the full latency still elapses, HI/LO are left unchanged, and no exception is raised.
- rdata: pure combinational mux of HI/LO. During busy it shows the old values; the consumer stalls.
- Reset asserted mid-operation overrides completion in the same edge.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: ops 7..10 are accepted with MULT_CYCLES latency. On completion, {HI,LO} = {HI,LO} ± product, where the product is signed for MADD/MSUB and unsigned for MADDU/MSUBU. Arithmetic is 64-bit and wraps. {HI,LO} is sampled at completion, not at accept.
- Not defined: codes 7..10 decode as NONE, cause no state change, and stall_req stays 0.

Test Plan:
- Reset, then rd_hi=0 and rd_hi=1 -> rdata=0, busy=0, stall_req=0.
- MULT A=0xFFFFFFFE, B=3 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x1234 at the accept edge, then DIVU by 0 -> busy 10 cycles, HI stays 0x1234, LO unchanged.
- Accept MULT, assert reset on cycle 3 of busy -> busy=0 and HI=LO=0 the next cycle; no later write. Also: start with cancel=1 -> no busy, no change.
- With MDU_MADD_EN defined: HI:LO=0:5, MADD A=2, B=3 -> after 5 cycles LO=11. Then MSUBU A=1, B=12 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF. Without the macro: op=7 gives busy=0 and HI/LO unchanged.
